// File: rtl/add8_err_monitor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | add8_errmon_pkg : FSM state type and width helpers for add8_err_monitor  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+

package add8_errmon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Sweep index covers every {a,b} operand pair.
  function automatic int idx_w(input int opw);
    return 2 * opw;
  endfunction

  function automatic int err_w(input int opw);
    return opw + 1;
  endfunction

  function automatic int cnt_w(input int opw);
    return 2 * opw + 1;
  endfunction

  function automatic int sae_w(input int opw);
    return 3 * opw + 1;
  endfunction

  function automatic int sse_w(input int opw);
    return 4 * opw + 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/add8_err_monitor_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | add8_err_monitor_if : control, adder and result bundle of the monitor    |
// | sse exists only with ADD8_ERRMON_MSE_EN.  Revision 1.0                   |
// +--------------------------------------------------------------------------+

interface add8_err_monitor_if
  import add8_errmon_pkg::*;
#(
  parameter int OPW = 8
) ();

  logic                    start;
  logic                    busy;
  logic                    done;
  logic [OPW-1:0]          op_a;
  logic [OPW-1:0]          op_b;
  logic [OPW:0]            approx_sum;
  logic [cnt_w(OPW)-1:0]   err_cnt;
  logic [OPW:0]            wce;
  logic [sae_w(OPW)-1:0]   sae;

`ifdef ADD8_ERRMON_MSE_EN
  logic [sse_w(OPW)-1:0]   sse;

  modport master (
    output start, approx_sum,
    input  busy, done, op_a, op_b, err_cnt, wce, sae, sse
  );

  modport slave (
    input  start, approx_sum,
    output busy, done, op_a, op_b, err_cnt, wce, sae, sse
  );
`else
  modport master (
    output start, approx_sum,
    input  busy, done, op_a, op_b, err_cnt, wce, sae
  );

  modport slave (
    input  start, approx_sum,
    output busy, done, op_a, op_b, err_cnt, wce, sae
  );
`endif

endinterface

`default_nettype wire

// File: rtl/add8_err_monitor_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | add8_err_accum : two-stage error computation and result accumulators     |
// | Squared-error path only with ADD8_ERRMON_MSE_EN.  Revision 1.0           |
// +--------------------------------------------------------------------------+

module add8_err_accum
  import add8_errmon_pkg::*;
#(
  parameter int OPW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [OPW-1:0]         in_a,
  input  logic [OPW-1:0]         in_b,
  input  logic [OPW:0]           in_sum,
  output logic [cnt_w(OPW)-1:0]  err_cnt,
  output logic [OPW:0]           wce,
  output logic [sae_w(OPW)-1:0]  sae
`ifdef ADD8_ERRMON_MSE_EN
  ,
  output logic [sse_w(OPW)-1:0]  sse
`endif
);

  localparam int ERR_W = err_w(OPW);
  localparam int CNT_W = cnt_w(OPW);
  localparam int SAE_W = sae_w(OPW);

  logic             s1_valid;
  logic [OPW-1:0]   s1_a;
  logic [OPW-1:0]   s1_b;
  logic [ERR_W-1:0] s1_sum;

  logic [ERR_W-1:0] exact;
  logic [ERR_W-1:0] err;
  logic             err_nz;

  // Stage 1: capture the pair and the adder's answer for it in one edge.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sum   <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_sum   <= in_sum;
    end
  end

  always_comb begin
    exact = {1'b0, s1_a} + {1'b0, s1_b};
    if (s1_sum >= exact) begin
      err = s1_sum - exact;
    end else begin
      err = exact - s1_sum;
    end
    err_nz = |err;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_cnt <= '0;
      wce     <= '0;
      sae     <= '0;
    end else if (s1_valid) begin
      err_cnt <= err_cnt + CNT_W'(err_nz);
      sae     <= sae + SAE_W'(err);
      if (err > wce) begin
        wce <= err;
      end
    end
  end

`ifdef ADD8_ERRMON_MSE_EN
  localparam int SSE_W = sse_w(OPW);

  logic [2*ERR_W-1:0] err_sq;

  // Operands widened first so the product keeps its full 2*ERR_W bits.
  assign err_sq = {{ERR_W{1'b0}}, err} * {{ERR_W{1'b0}}, err};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sse <= '0;
    end else if (s1_valid) begin
      sse <= sse + SSE_W'(err_sq);
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/add8_err_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | add8_err_monitor : exhaustive operand sweep and error characterisation   |
// | of an external approximate adder; sse with ADD8_ERRMON_MSE_EN. Rev 1.0   |
// +--------------------------------------------------------------------------+

module add8_err_monitor
  import add8_errmon_pkg::*;
#(
  parameter int OPW = 8
) (
  input  logic               clk,
  input  logic               rst,
  add8_err_monitor_if.slave  mon
);

  localparam int IDX_W = idx_w(OPW);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  state_t            state;
  state_t            state_nxt;
  logic              clear;
  logic [IDX_W-1:0]  idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (mon.start) begin
          clear     = 1'b1;
          state_nxt = SWEEP;
        end
      end
      SWEEP: begin
        if (idx == IDX_LAST) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // idx wraps back to 0 after the last pair, so operands read 0 outside SWEEP.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx <= '0;
    end else if (state == SWEEP) begin
      idx <= idx + 1'b1;
    end
  end

  assign mon.op_a = idx[IDX_W-1:OPW];
  assign mon.op_b = idx[OPW-1:0];
  assign mon.busy = (state == SWEEP) || (state == DRAIN);
  assign mon.done = (state == DONE);

  add8_err_accum #(
    .OPW (OPW)
  ) u_accum (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (state == SWEEP),
    .in_a     (mon.op_a),
    .in_b     (mon.op_b),
    .in_sum   (mon.approx_sum),
    .err_cnt  (mon.err_cnt),
    .wce      (mon.wce),
    .sae      (mon.sae)
`ifdef ADD8_ERRMON_MSE_EN
    ,
    .sse      (mon.sse)
`endif
  );

endmodule

`default_nettype wire
